// File: rtl/uart_div_seq.sv
// uart_div_seq: collects 4-byte divide requests from the UART, drives a shared divider,
// and returns quotient/remainder as 4 bytes; zero divisors are answered locally.
module uart_div_seq #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              div_start,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quot,
    input  logic [DATA_W-1:0] div_rem,
    output logic              tx_ready,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              dz_flag,
    output logic              timeout_err,
    output logic              overrun_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, RX_COLLECT, START, WAIT_DIV, TX_SEND, TX_GUARD, TX_WAIT} state_t;

    state_t state, state_nxt;
    logic rx_prev, rx_edge, accept, last, zero;
    logic [1:0] cnt, idx;
    logic [TW-1:0] tmr;
    logic [2*DATA_W-1:0] frame, res;

    assign rx_edge      = rx_ready & ~rx_prev;
    assign busy         = !(state == IDLE || state == RX_COLLECT);
    assign accept       = rx_edge & ~busy;
    assign timeout_err  = state == RX_COLLECT && tmr == TW'(TIMEOUT_CYC - 1);
    assign last         = state == RX_COLLECT && !timeout_err && rx_edge && cnt == 2'd3;
    assign zero         = {frame[7:0], rx_data} == '0;
    assign dz_flag      = last & zero;
    assign overrun_err  = rx_edge & busy;
    assign tx_ready     = state == TX_SEND && !tx_busy;
    // Bytes leave most-significant first: quot_hi, quot_lo, rem_hi, rem_lo.
    assign tx_data      = tx_ready ? 8'(res >> {~idx, 3'b000}) : 8'h00;
    assign div_dividend = frame[2*DATA_W-1:DATA_W];
    assign div_divisor  = frame[DATA_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = rx_edge ? RX_COLLECT : IDLE;
            RX_COLLECT: state_nxt = timeout_err ? (rx_edge ? RX_COLLECT : IDLE)
                                  : last ? (zero ? TX_SEND : START) : RX_COLLECT;
            START:      state_nxt = WAIT_DIV;
            WAIT_DIV:   state_nxt = div_done ? TX_SEND : WAIT_DIV;
            TX_SEND:    state_nxt = tx_ready ? TX_GUARD : TX_SEND;
            TX_GUARD:   state_nxt = TX_WAIT;
            TX_WAIT:    state_nxt = tx_busy ? TX_WAIT : (idx == 2'd3 ? IDLE : TX_SEND);
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_prev   <= 1'b0;
            cnt       <= 2'd0;
            idx       <= 2'd0;
            tmr       <= '0;
            frame     <= '0;
            res       <= '0;
            div_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_prev   <= rx_ready;
            div_start <= state == START;
            tmr       <= (state != RX_COLLECT || rx_edge || timeout_err) ? '0 : (&tmr ? tmr : tmr + TW'(1));
            // A byte arriving with the timeout restarts the frame as its first byte.
            if (accept) begin
                frame <= {frame[2*DATA_W-9:0], rx_data};
                cnt   <= (state == IDLE || timeout_err) ? 2'd1 : cnt + 2'd1;
            end else if (timeout_err) begin
                cnt <= 2'd0;
            end
            if (last && zero)
                res <= {{DATA_W{1'b1}}, frame[2*DATA_W-9:8]};
            else if (state == WAIT_DIV && div_done)
                res <= {div_quot, div_rem};
            if (last || (state == WAIT_DIV && div_done))
                idx <= 2'd0;
            else if (state == TX_WAIT && !tx_busy)
                idx <= idx + 2'd1;
        end
    end
endmodule
